// File: rtl/mix_columns_seq.sv
// Iterative AES (Inv)MixColumns, COLS_PER_CYCLE columns per clock; INV_MIX_EN adds the inverse matrix.
// Latency: 4/COLS_PER_CYCLE cycles from acceptance to outValid; lastRound bypass has identical timing.
// Backpressure: result is held in DONE until outReady; inReady is low from acceptance until transfer.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] shifted,
   input  logic         inValid,
   output logic         inReady,
   input  logic         lastRound,
   input  logic         inverse,
   output logic [127:0] mixed,
   output logic         outValid,
   input  logic         outReady
);

   localparam int NCYC = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] LASTCNT = 2'(NCYC - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       cnt;
   logic [3:0][31:0] st_q, mix_q, mix_nxt;
   logic             lr_q;
   logic             accept;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
   endfunction

   // Packed word 3 holds column 0 (MSB end), so column c lives at word 3-c.
   function automatic logic [1:0] word_idx(input logic [1:0] cn, input int k);
      return 2'(3 - (int'(cn) * COLS_PER_CYCLE + k));
   endfunction

`ifdef INV_MIX_EN
   logic inv_q;

   // 9, B, D, E multiples from the x2/x4/x8 chain.
   function automatic logic [31:0] mul_row(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xt(b);
      x4 = xt(x2);
      x8 = xt(x4);
      return {x8 ^ x4 ^ x2, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ b};
   endfunction

   function automatic logic [31:0] mix_inv(input logic [31:0] c);
      logic [7:0] e0, b0, d0, n0, e1, b1, d1, n1, e2, b2, d2, n2, e3, b3, d3, n3;
      {e0, b0, d0, n0} = mul_row(c[31:24]);
      {e1, b1, d1, n1} = mul_row(c[23:16]);
      {e2, b2, d2, n2} = mul_row(c[15:8]);
      {e3, b3, d3, n3} = mul_row(c[7:0]);
      return {e0 ^ b1 ^ d2 ^ n3,
              n0 ^ e1 ^ b2 ^ d3,
              d0 ^ n1 ^ e2 ^ b3,
              b0 ^ d1 ^ n2 ^ e3};
   endfunction
`else
   logic unused_inverse;
   assign unused_inverse = inverse;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      inReady   = 1'b0;
      outValid  = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            inReady = 1'b1;
            if (inValid) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: if (cnt == LASTCNT) state_nxt = DONE;
         DONE: begin
            outValid = 1'b1;
            if (outReady) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mix_nxt = mix_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef INV_MIX_EN
         mix_nxt[word_idx(cnt, k)] = lr_q  ? st_q[word_idx(cnt, k)] :
                                     inv_q ? mix_inv(st_q[word_idx(cnt, k)]) :
                                             mix_fwd(st_q[word_idx(cnt, k)]);
`else
         mix_nxt[word_idx(cnt, k)] = lr_q ? st_q[word_idx(cnt, k)] :
                                            mix_fwd(st_q[word_idx(cnt, k)]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= '0;
         mix_q <= '0;
         cnt   <= '0;
         lr_q  <= 1'b0;
`ifdef INV_MIX_EN
         inv_q <= 1'b0;
`endif
      end else begin
         if (accept) begin
            st_q <= shifted;
            lr_q <= lastRound;
            cnt  <= '0;
`ifdef INV_MIX_EN
            inv_q <= inverse;
`endif
         end
         if (state == BUSY) begin
            mix_q <= mix_nxt;
            cnt   <= cnt + 2'd1;
         end
      end
   end

   assign mixed = mix_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Runs COLS_PER_CYCLE = 1, 2, 4 side by side on shared stimulus against a GF(2^8) matrix model.
module tb_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] shifted;
   logic         inValid, lastRound, inverse, outReady;
   logic         inReady_a  [3];
   logic         outValid_a [3];
   logic [127:0] mixed_a    [3];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk      (clk),
         .rst      (rst),
         .shifted  (shifted),
         .inValid  (inValid),
         .inReady  (inReady_a[g]),
         .lastRound(lastRound),
         .inverse  (inverse),
         .mixed    (mixed_a[g]),
         .outValid (outValid_a[g]),
         .outReady (outReady)
      );
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Row r of the circulant matrix is the base row rotated right by r.
   function automatic logic [7:0] coef(input logic inv, input int r, input int j);
      int idx;
      idx = (j - r + 4) % 4;
      if (inv) begin
         case (idx)
            0: return 8'h0E;
            1: return 8'h0B;
            2: return 8'h0D;
            default: return 8'h09;
         endcase
      end else begin
         case (idx)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
         endcase
      end
   endfunction

   function automatic logic [127:0] model(input logic [127:0] din, input logic lr, input logic inv);
      logic [127:0] res;
      logic [7:0] acc;
      if (lr) return din;
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef(inv, r, j), din[127 - 8*(4*c + j) -: 8]);
            res[127 - 8*(4*c + r) -: 8] = acc;
         end
      return res;
   endfunction

   function automatic logic eff_inv(input logic inv);
`ifdef INV_MIX_EN
      return inv;
`else
      return 1'b0 & inv;
`endif
   endfunction

   task automatic chk(input string tag, input int g, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[cpc%0d] observed=%h expected=%h", tag, 1 << g, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One block through all three instances with outReady high throughout.
   task automatic run_block(input string tag, input logic [127:0] din, input logic lr,
                            input logic inv, input logic [127:0] exp);
      int lat [3];
      int dur [3];
      for (int g = 0; g < 3; g++) begin
         lat[g] = 0; dur[g] = 0;
         chk({tag, ".inReady"}, g, 128'(inReady_a[g]), 128'd1);
      end
      shifted = din; lastRound = lr; inverse = inv; inValid = 1'b1; outReady = 1'b1;
      step();
      inValid = 1'b0; shifted = ~din; lastRound = ~lr; inverse = ~inv;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         step();
         for (int g = 0; g < 3; g++)
            if (outValid_a[g]) begin
               dur[g]++;
               if (lat[g] == 0) begin
                  lat[g] = cyc;
                  chk({tag, ".mixed"}, g, mixed_a[g], exp);
               end
            end
      end
      for (int g = 0; g < 3; g++) begin
         chk({tag, ".latency"}, g, 128'(lat[g]), 128'(4 >> g));
         chk({tag, ".valid_len"}, g, 128'(dur[g]), 128'd1);
         chk({tag, ".inReady_after"}, g, 128'(inReady_a[g]), 128'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] din, exp;
      logic lr, inv;

      rst = 1'b1; shifted = '0; inValid = 1'b0; lastRound = 1'b0; inverse = 1'b0; outReady = 1'b1;
      @(negedge clk);
      step();
      for (int g = 0; g < 3; g++) begin
         chk("reset.mixed", g, mixed_a[g], '0);
         chk("reset.outValid", g, 128'(outValid_a[g]), '0);
         chk("reset.inReady", g, 128'(inReady_a[g]), 128'd1);
      end
      rst = 1'b0;
      step();

      run_block("fips", 128'hD4BF5D30E0B452AEB84111F11E2798E5, 1'b0, 1'b0,
                128'h046681E5E0CB199A48F8D37A2806264C);
      run_block("corner", 128'hDB135345F20A225C01010101C6C6C6C6, 1'b0, 1'b0,
                128'h8E4DA1BC9FDC589D01010101C6C6C6C6);
      run_block("bypass", 128'h632FAFA2EB93C7209F92ABCBA0C0302B, 1'b1, 1'b0,
                128'h632FAFA2EB93C7209F92ABCBA0C0302B);

      din = 128'h046681E5E0CB199A48F8D37A2806264C;
`ifdef INV_MIX_EN
      exp = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
`else
      exp = model(din, 1'b0, 1'b0);
`endif
      run_block("inverse", din, 1'b0, 1'b1, exp);

      // Backpressure: hold DONE for 10 cycles with a stray inValid pulse.
      din = 128'hDB135345F20A225C01010101C6C6C6C6;
      exp = 128'h8E4DA1BC9FDC589D01010101C6C6C6C6;
      shifted = din; lastRound = 1'b0; inverse = 1'b0; inValid = 1'b1; outReady = 1'b0;
      step();
      inValid = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin inValid = 1'b1; shifted = {$urandom, $urandom, $urandom, $urandom}; end
         if (i == 5) inValid = 1'b0;
         step();
         for (int g = 0; g < 3; g++) begin
            chk("bp.outValid", g, 128'(outValid_a[g]), 128'd1);
            chk("bp.inReady", g, 128'(inReady_a[g]), '0);
            chk("bp.mixed", g, mixed_a[g], exp);
         end
      end
      outReady = 1'b1;
      step();
      for (int g = 0; g < 3; g++) begin
         chk("bp.release_outValid", g, 128'(outValid_a[g]), '0);
         chk("bp.release_inReady", g, 128'(inReady_a[g]), 128'd1);
      end
      repeat (5) begin
         step();
         for (int g = 0; g < 3; g++)
            chk("bp.pulse_ignored", g, 128'(outValid_a[g]), '0);
      end

      // Reset landing on the second BUSY cycle.
      shifted = 128'hD4BF5D30E0B452AEB84111F11E2798E5; inValid = 1'b1; outReady = 1'b0;
      step();
      inValid = 1'b0;
      step();
      rst = 1'b1;
      step();
      for (int g = 0; g < 3; g++) begin
         chk("midrst.mixed", g, mixed_a[g], '0);
         chk("midrst.outValid", g, 128'(outValid_a[g]), '0);
         chk("midrst.inReady", g, 128'(inReady_a[g]), 128'd1);
      end
      rst = 1'b0; outReady = 1'b1;
      step();
      run_block("post_rst", 128'hD4BF5D30E0B452AEB84111F11E2798E5, 1'b0, 1'b0,
                128'h046681E5E0CB199A48F8D37A2806264C);

      repeat (24) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         lr  = ($urandom_range(0, 3) == 0);
         inv = 1'($urandom_range(0, 1));
         run_block("random", din, lr, inv, model(din, lr, eff_inv(inv)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Iterative AES MixColumns stage sitting directly downstream of the ShiftRows stage. Consumes the 128-bit shifted state, applies the MixColumns GF(2^8) matrix one group of columns per cycle, and presents the mixed state to AddRoundKey through a valid/ready handshake. Supports last-round bypass. An optional inverse mode serves the decryption datapath.

## Interface
- `COLS_PER_CYCLE`, default 1: columns processed per clock; legal values 1, 2, 4. `NCYC = 4/COLS_PER_CYCLE`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `shifted`  in  128  input state; byte 0 = [127:120]; column-major, so column c = bits [127-32c -: 32], row 0 is the MSB byte.
- `inValid`  in  1  `shifted`/`lastRound`/`inverse` are valid.
- `inReady`  out  1  block can accept an input.
- `lastRound`  in  1  bypass: output equals input, same latency.
- `inverse`  in  1  select InvMixColumns; only honoured with `INV_MIX_EN`.
- `mixed`  out  128  result state, same byte layout.
- `outValid`  out  1  `mixed` holds a complete result.
- `outReady`  in  1  downstream accepts `mixed`.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `inReady`=1. When `inValid` is high, capture `shifted`, `lastRound` and `inverse`, clear the column counter, and go to BUSY.
  - BUSY: each cycle, process columns `cnt*COLS_PER_CYCLE` upward and write them into the matching slice of `mixed`. Increment `cnt`. After the `NCYC`th write, go to DONE.
  - DONE: `outValid`=1. `mixed` stays stable. When `outReady` is high, go to IDLE.
- In BUSY and DONE, `inReady`=0 and `inValid` is ignored. There is no overlap of blocks.
- During BUSY, columns not yet processed keep their previous contents. `mixed` is only meaningful while `outValid`=1.
- Arithmetic, forward mode:
  - `xt(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0)`.
  - `r0 = 2a0^3a1^a2^a3`
  - `r1 = a0^2a1^3a2^a3`
  - `r2 = a0^a1^2a2^3a3`
  - `r3 = 3a0^a1^a2^2a3`
  - where 2x = xt(x) and 3x = xt(x)^x. All results are 8-bit with no carries.
- Arithmetic, inverse mode: coefficient rows {0E,0B,0D,09} rotated per row, built from chained xt.
- `lastRound`=1: each column is copied unchanged. Cycle behaviour is identical to normal mode.
- Reset: state → IDLE, counter → 0, captured input → 0. Outputs: `mixed`=0, `outValid`=0, `inReady`=1 in the cycle after the reset edge. A reset mid-BUSY or in DONE discards the block silently.
- `rst` has priority over every handshake in the same cycle.

## Timing
- Acceptance at edge E0 (IDLE, `inValid`=1).
- One column group is written on each of edges E1..E`NCYC`.
- `outValid` rises after E`NCYC`. Latency is 4 cycles for `COLS_PER_CYCLE`=1 and 1 cycle for `COLS_PER_CYCLE`=4.
- The output transfer happens at the first edge with `outValid`&`outReady`. `inReady`=1 in the following cycle.
- Maximum throughput is one block per `NCYC`+2 cycles.
- If `outReady` is held high while in DONE, DONE lasts exactly one cycle.
- Backpressure: DONE holds indefinitely with `mixed` unchanged.

## Configuration
- `INV_MIX_EN` defined: the `inverse` input is sampled at acceptance, and inverse mode uses the InvMixColumns coefficients.
- `INV_MIX_EN` undefined:
  - the port remains but is ignored (treated as 0);
  - the inverse multiplier logic is not synthesised;
  - forward results are bit-identical to the defined build.

## Test plan
- FIPS-197 round 1, `COLS_PER_CYCLE`=1, `outReady`=1:
  - `shifted`=D4BF5D30E0B452AEB84111F11E2798E5 → `mixed`=046681E5E0CB199A48F8D37A2806264C;
  - `outValid` asserts exactly 4 cycles after acceptance and lasts 1 cycle.
- Column corner cases in one block:
  - `shifted`=DB135345F20A225C01010101C6C6C6C6 → `mixed`=8E4DA1BC9FDC589D01010101C6C6C6C6;
  - repeat with `COLS_PER_CYCLE`=2 and 4, checking latency is 2 and 1.
- `lastRound`=1 with `shifted`=632FAFA2EB93C7209F92ABCBA0C0302B → `mixed` equals the input. Latency is unchanged.
- Backpressure:
  - hold `outReady`=0 for 10 cycles in DONE → `mixed` and `outValid` stay stable, and `inReady`=0;
  - a pulse on `inValid` during that window is ignored;
  - release → transfer, then `inReady`=1 the next cycle.
- Reset asserted on the 2nd BUSY cycle → next cycle `mixed`=0, `outValid`=0, `inReady`=1. A new block then completes correctly.
- With `INV_MIX_EN`, `inverse`=1: `shifted`=046681E5E0CB199A48F8D37A2806264C → `mixed`=D4BF5D30E0B452AEB84111F11E2798E5. Without the macro, the same stimulus yields the forward result.
